// File: rtl/classifier_output_stage.sv
// Output stage for the four-perceptron layer: snapshots the neuron outputs on start,
// runs a sequential arg-max and presents results through a registered output mux.
module classifier_output_stage #(
  parameter bit SIGNED = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] neuron0_output,
  input  logic [7:0] neuron1_output,
  input  logic [7:0] neuron2_output,
  input  logic [7:0] neuron3_output,
  input  logic       start,
  input  logic [1:0] out_sel,
  input  logic [1:0] byte_sel,
  output logic       busy,
  output logic       done,
  output logic [1:0] class_idx,
  output logic [7:0] network_outputs
);

  // state | meaning
  // IDLE  | waiting for start; results held stable
  // CMP   | one compare of snap[ptr] against the running best per edge
  // FIN   | commit best to the result registers, pulse done
  typedef enum logic [1:0] {IDLE, CMP, FIN} state_t;

  state_t     state_q;
  logic [7:0] snap_q [4];
  logic [7:0] best_val_q;
  logic [1:0] best_idx_q;
  logic [1:0] ptr_q;
  logic       busy_q;
  logic       done_q;
  logic [1:0] class_idx_q;
  logic [7:0] max_val_q;
  logic [3:0] onehot_q;
  logic [7:0] count_q;
  logic [7:0] net_out_q;

  logic [7:0] cand_d;
  logic       cand_gt_d;
  logic [7:0] net_out_d;

  assign cand_d = snap_q[ptr_q];
  // Strict compare keeps the lowest index on ties.
  assign cand_gt_d = SIGNED ? ($signed(cand_d) > $signed(best_val_q))
                            : (cand_d > best_val_q);

  always_comb begin
    net_out_d = 8'h00;
    case (out_sel)
      2'd0:    net_out_d = {onehot_q, 2'b00, class_idx_q};
      2'd1:    net_out_d = max_val_q;
      2'd2:    net_out_d = count_q;
      default: net_out_d = snap_q[byte_sel];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      for (int i = 0; i < 4; i++) snap_q[i] <= 8'h00;
      best_val_q  <= 8'h00;
      best_idx_q  <= 2'd0;
      ptr_q       <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      class_idx_q <= 2'd0;
      max_val_q   <= 8'h00;
      onehot_q    <= 4'h0;
      count_q     <= 8'h00;
      net_out_q   <= 8'h00;
    end else begin
      done_q    <= 1'b0;
      net_out_q <= net_out_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            snap_q[0]  <= neuron0_output;
            snap_q[1]  <= neuron1_output;
            snap_q[2]  <= neuron2_output;
            snap_q[3]  <= neuron3_output;
            best_val_q <= neuron0_output;
            best_idx_q <= 2'd0;
            ptr_q      <= 2'd1;
            busy_q     <= 1'b1;
            state_q    <= CMP;
          end
        end
        CMP: begin
          if (cand_gt_d) begin
            best_val_q <= cand_d;
            best_idx_q <= ptr_q;
          end
          ptr_q <= ptr_q + 2'd1;
          if (ptr_q == 2'd3) state_q <= FIN;
        end
        FIN: begin
          class_idx_q <= best_idx_q;
          max_val_q   <= best_val_q;
          onehot_q    <= 4'b0001 << best_idx_q;
          count_q     <= count_q + 8'd1;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign class_idx       = class_idx_q;
  assign network_outputs = net_out_q;

endmodule

// File: tb/tb_classifier_output_stage.sv
// Directed bench for classifier_output_stage; a signed and an unsigned instance
// share the same stimulus so signedness differences show side by side.
module tb_classifier_output_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] n0, n1, n2, n3;
  logic       start;
  logic [1:0] out_sel, byte_sel;
  logic       busy_s, done_s, busy_u, done_u;
  logic [1:0] class_s, class_u;
  logic [7:0] net_s, net_u;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  classifier_output_stage #(.SIGNED(1'b1)) u_s (
    .clk(clk), .reset(reset),
    .neuron0_output(n0), .neuron1_output(n1), .neuron2_output(n2), .neuron3_output(n3),
    .start(start), .out_sel(out_sel), .byte_sel(byte_sel),
    .busy(busy_s), .done(done_s), .class_idx(class_s), .network_outputs(net_s)
  );

  classifier_output_stage #(.SIGNED(1'b0)) u_u (
    .clk(clk), .reset(reset),
    .neuron0_output(n0), .neuron1_output(n1), .neuron2_output(n2), .neuron3_output(n3),
    .start(start), .out_sel(out_sel), .byte_sel(byte_sel),
    .busy(busy_u), .done(done_u), .class_idx(class_u), .network_outputs(net_u)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulses start for one edge (k) and steps to the sample point just after k+4.
  task automatic run_class(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d,
                           input bit corrupt, input string tag);
    @(negedge clk);
    n0 = a; n1 = b; n2 = c; n3 = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_k"}, busy_s, 1);
    chk({tag, "_done_k"}, done_s, 0);
    if (corrupt) begin
      n0 = 8'h7F; n1 = 8'h7F; n2 = 8'h7F; n3 = 8'h7F;
    end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk({tag, "_busy_cmp"}, busy_s, 1);
      chk({tag, "_done_cmp"}, done_s, 0);
    end
    @(negedge clk);
    chk({tag, "_done_fin"}, done_s, 1);
    chk({tag, "_busy_fin"}, busy_s, 0);
    chk({tag, "_done_u_fin"}, done_u, 1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_s) break;
    end
    if (!done_s) chk({tag, "_timeout"}, done_s, 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int d_first, d_second, d_cnt;
    bit seen;
    reset = 1'b1; start = 1'b0;
    n0 = 8'h00; n1 = 8'h00; n2 = 8'h00; n3 = 8'h00;
    out_sel = 2'd0; byte_sel = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_s, 0);
    chk("rst_done", done_s, 0);
    chk("rst_class", class_s, 0);
    chk("rst_net", net_s, 0);
    reset = 1'b0;

    // Basic arg-max
    out_sel = 2'd0;
    run_class(8'h05, 8'h20, 8'h10, 8'h01, 1'b0, "basic");
    chk("basic_class", class_s, 1);
    @(negedge clk);
    chk("basic_done_after", done_s, 0);
    chk("basic_view0", net_s, 8'h21);
    out_sel = 2'd1;
    @(negedge clk);
    chk("basic_view1", net_s, 8'h20);
    out_sel = 2'd2;
    @(negedge clk);
    chk("basic_count", net_s, 8'h01);

    // Signedness and ties
    out_sel = 2'd1;
    run_class(8'h80, 8'h7F, 8'hFF, 8'h7F, 1'b0, "sign");
    chk("sign_class_s", class_s, 1);
    chk("sign_class_u", class_u, 2);
    @(negedge clk);
    chk("sign_max_s", net_s, 8'h7F);
    chk("sign_max_u", net_u, 8'hFF);

    // Snapshot isolation
    run_class(8'h01, 8'h02, 8'h03, 8'h04, 1'b1, "snap");
    chk("snap_class_s", class_s, 3);
    chk("snap_class_u", class_u, 3);
    out_sel = 2'd3;
    for (int b = 0; b < 4; b++) begin
      byte_sel = 2'(b);
      @(negedge clk);
      chk("snap_byte", net_s, 32'(b + 1));
    end

    // Held start: observe 12 cycles; accepts at k, k+5, k+10
    pulse_reset();
    out_sel = 2'd2;
    d_first = -1; d_second = -1; d_cnt = 0;
    start = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (done_s) begin
        d_cnt++;
        if (d_first < 0) d_first = j; else if (d_second < 0) d_second = j;
      end
      if (j == 4)  chk("held_busy_fin", busy_s, 0);
      if (j == 5)  chk("held_busy_reacc", busy_s, 1);
      if (j == 10) chk("held_count", net_s, 8'h02);
    end
    start = 1'b0;
    chk("held_done_cnt", d_cnt, 2);
    chk("held_done_first", d_first, 4);
    chk("held_done_space", d_second - d_first, 5);
    wait_done("held_drain");

    // Reset mid-operation
    pulse_reset();
    out_sel = 2'd2;
    @(negedge clk);
    n0 = 8'h05; n1 = 8'h20; n2 = 8'h10; n3 = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rmid_busy", busy_s, 0);
    chk("rmid_net", net_s, 0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done_s) seen = 1'b1;
    end
    chk("rmid_no_done", seen, 0);
    chk("rmid_count", net_s, 0);
    run_class(8'h05, 8'h20, 8'h10, 8'h01, 1'b0, "rmid_fresh");
    chk("rmid_fresh_class", class_s, 1);
    @(negedge clk);
    chk("rmid_fresh_count", net_s, 8'h01);

    // Counter wrap over 256 back-to-back classifications
    pulse_reset();
    out_sel = 2'd2;
    start = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      wait_done("wrap");
      if (i == 256) start = 1'b0;
      @(negedge clk);
      if (i == 255) chk("wrap_255", net_s, 8'hFF);
      if (i == 256) chk("wrap_256", net_s, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
